// File: rtl/emb_train_ctrl_if.sv
// Handshake bundle between the training controller and the embedding layer.
// The controller side uses the master modport; the embedding layer (or a bench) uses slave.
interface emb_train_ctrl_if;
  logic        start;
  logic        valid_zero_grad;
  logic        valid_forward;
  logic        valid_backward;
  logic        valid_update;
  logic        zero_grad;
  logic        run_forward;
  logic        run_backward;
  logic        update;
  logic        load_backward;
  logic [7:0]  fwd_idx;
  logic [7:0]  bwd_idx;
  logic [15:0] batch_cnt;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  valid_zero_grad,
    input  valid_forward,
    input  valid_backward,
    input  valid_update,
    output zero_grad,
    output run_forward,
    output run_backward,
    output update,
    output load_backward,
    output fwd_idx,
    output bwd_idx,
    output batch_cnt,
    output busy,
    output done
  );

  modport slave (
    output start,
    output valid_zero_grad,
    output valid_forward,
    output valid_backward,
    output valid_update,
    input  zero_grad,
    input  run_forward,
    input  run_backward,
    input  update,
    input  load_backward,
    input  fwd_idx,
    input  bwd_idx,
    input  batch_cnt,
    input  busy,
    input  done
  );
endinterface

// File: rtl/emb_train_ctrl.sv
// Mini-batch training sequencer: zero-grad + forward, pipelined forward/backward pairs,
// trailing backward, then weight update, repeated NUM_BATCH times per start.
module emb_train_ctrl #(
  parameter int unsigned BATCH_SIZE = 2,
  parameter int unsigned NUM_BATCH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  emb_train_ctrl_if.master  bus
);

  localparam logic [7:0]  BATCH_LEN   = 8'(BATCH_SIZE);
  localparam logic [7:0]  LAST_SAMPLE = 8'(BATCH_SIZE - 1);
  localparam logic [15:0] LAST_BATCH  = 16'(NUM_BATCH - 1);

  typedef enum logic [3:0] {
    IDLE,
    S1_REQ,
    S1_REL,
    LOADB,
    S2_REQ,
    S2_REL,
    S3_REQ,
    S3_REL,
    UPD_REQ,
    UPD_REL
  } state_t;

  state_t      state_reg, state_next;
  logic        fwd_seen_reg, fwd_seen_next;
  logic        bwd_seen_reg, bwd_seen_next;
  logic [7:0]  fwd_idx_reg, fwd_idx_next;
  logic [7:0]  bwd_idx_reg, bwd_idx_next;
  logic [15:0] batch_cnt_reg, batch_cnt_next;
  logic        zero_grad_reg, zero_grad_next;
  logic        run_forward_reg, run_forward_next;
  logic        run_backward_reg, run_backward_next;
  logic        update_reg, update_next;
  logic        load_backward_reg, load_backward_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  // In the pipelined phase each acknowledge may arrive on its own cycle, so an
  // earlier arrival is remembered until its partner shows up.
  logic fwd_hit, bwd_hit;
  assign fwd_hit = fwd_seen_reg | bus.valid_forward;
  assign bwd_hit = bwd_seen_reg | bus.valid_backward;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      fwd_seen_reg      <= 1'b0;
      bwd_seen_reg      <= 1'b0;
      fwd_idx_reg       <= 8'd0;
      bwd_idx_reg       <= 8'd0;
      batch_cnt_reg     <= 16'd0;
      zero_grad_reg     <= 1'b0;
      run_forward_reg   <= 1'b0;
      run_backward_reg  <= 1'b0;
      update_reg        <= 1'b0;
      load_backward_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      fwd_seen_reg      <= fwd_seen_next;
      bwd_seen_reg      <= bwd_seen_next;
      fwd_idx_reg       <= fwd_idx_next;
      bwd_idx_reg       <= bwd_idx_next;
      batch_cnt_reg     <= batch_cnt_next;
      zero_grad_reg     <= zero_grad_next;
      run_forward_reg   <= run_forward_next;
      run_backward_reg  <= run_backward_next;
      update_reg        <= update_next;
      load_backward_reg <= load_backward_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = S1_REQ;
      end
      S1_REQ: begin
        if (bus.valid_zero_grad && bus.valid_forward) state_next = S1_REL;
      end
      S1_REL: begin
        if (!bus.valid_zero_grad && !bus.valid_forward) state_next = LOADB;
      end
      LOADB: begin
        if ((fwd_idx_reg != 8'd0) && (fwd_idx_reg < BATCH_LEN)) state_next = S2_REQ;
        else                                                    state_next = S3_REQ;
      end
      S2_REQ: begin
        if (fwd_hit && bwd_hit) state_next = S2_REL;
      end
      S2_REL: begin
        if (!bus.valid_forward && !bus.valid_backward) state_next = LOADB;
      end
      S3_REQ: begin
        if (bus.valid_backward) state_next = S3_REL;
      end
      S3_REL: begin
        if (!bus.valid_backward) state_next = UPD_REQ;
      end
      UPD_REQ: begin
        if (bus.valid_update) state_next = UPD_REL;
      end
      UPD_REL: begin
        if (!bus.valid_update) begin
          if (batch_cnt_reg < LAST_BATCH) state_next = S1_REQ;
          else                            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered, so every
  // request is stable for the whole time its *_REQ state is occupied.
  always_comb begin
    fwd_idx_next   = fwd_idx_reg;
    bwd_idx_next   = bwd_idx_reg;
    batch_cnt_next = batch_cnt_reg;
    fwd_seen_next  = 1'b0;
    bwd_seen_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (state_next == S1_REQ) begin
          fwd_idx_next   = 8'd0;
          bwd_idx_next   = 8'd0;
          batch_cnt_next = 16'd0;
        end
      end
      S1_REL: begin
        if (state_next == LOADB) begin
          if (BATCH_SIZE > 1) fwd_idx_next = 8'd1;
          bwd_idx_next = 8'd0;
        end
      end
      LOADB: begin
        if (state_next == S3_REQ) bwd_idx_next = LAST_SAMPLE;
      end
      S2_REQ: begin
        if (state_next == S2_REQ) begin
          fwd_seen_next = fwd_hit;
          bwd_seen_next = bwd_hit;
        end
      end
      S2_REL: begin
        if (state_next == LOADB) begin
          fwd_idx_next = fwd_idx_reg + 8'd1;
          bwd_idx_next = bwd_idx_reg + 8'd1;
        end
      end
      UPD_REL: begin
        if (state_next == S1_REQ) begin
          batch_cnt_next = batch_cnt_reg + 16'd1;
          fwd_idx_next   = 8'd0;
          bwd_idx_next   = 8'd0;
        end
      end
      default: begin
        fwd_idx_next = fwd_idx_reg;
      end
    endcase

    zero_grad_next     = (state_next == S1_REQ);
    run_forward_next   = (state_next == S1_REQ) || (state_next == S2_REQ);
    run_backward_next  = (state_next == S2_REQ) || (state_next == S3_REQ);
    update_next        = (state_next == UPD_REQ);
    load_backward_next = (state_next == LOADB);
    busy_next          = (state_next != IDLE);
    done_next          = (state_reg == UPD_REL) && (state_next == IDLE);
  end

  assign bus.zero_grad     = zero_grad_reg;
  assign bus.run_forward   = run_forward_reg;
  assign bus.run_backward  = run_backward_reg;
  assign bus.update        = update_reg;
  assign bus.load_backward = load_backward_reg;
  assign bus.fwd_idx       = fwd_idx_reg;
  assign bus.bwd_idx       = bwd_idx_reg;
  assign bus.batch_cnt     = batch_cnt_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;

endmodule

// File: tb/tb_emb_train_ctrl.sv
// Directed bench for emb_train_ctrl: two instances (B=2/N=1 and B=1/N=2) driven by a
// delay/hold acknowledge model or by hand-stepped valids.
module tb_emb_train_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic start_a, start_b;
  logic [3:0] auto_a, auto_b;   // per channel: 1 = model drives valid
  logic [3:0] man_a, man_b;     // hand-driven valids
  logic [3:0] mdl_a = 4'h0;
  logic [3:0] mdl_b = 4'h0;
  int dly, hold;
  int cnt_a[4], hcnt_a[4], cnt_b[4], hcnt_b[4];
  logic sel;                    // 0 observes instance a, 1 instance b

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ev_q[$];
  int lb_cnt, done_cnt;

  localparam logic [31:0] M_ALL   = 32'h0FFF_FFFF;
  localparam logic [31:0] M_S1    = 32'h0FFF_00FF;
  localparam logic [31:0] M_NOFWD = 32'h0F00_FFFF;
  localparam logic [31:0] M_REQB  = 32'h0F00_00FF;

  emb_train_ctrl_if bus_a();
  emb_train_ctrl_if bus_b();

  emb_train_ctrl #(.BATCH_SIZE(2), .NUM_BATCH(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  emb_train_ctrl #(.BATCH_SIZE(1), .NUM_BATCH(2)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  assign bus_a.start           = start_a;
  assign bus_a.valid_zero_grad = auto_a[0] ? mdl_a[0] : man_a[0];
  assign bus_a.valid_forward   = auto_a[1] ? mdl_a[1] : man_a[1];
  assign bus_a.valid_backward  = auto_a[2] ? mdl_a[2] : man_a[2];
  assign bus_a.valid_update    = auto_a[3] ? mdl_a[3] : man_a[3];
  assign bus_b.start           = start_b;
  assign bus_b.valid_zero_grad = auto_b[0] ? mdl_b[0] : man_b[0];
  assign bus_b.valid_forward   = auto_b[1] ? mdl_b[1] : man_b[1];
  assign bus_b.valid_backward  = auto_b[2] ? mdl_b[2] : man_b[2];
  assign bus_b.valid_update    = auto_b[3] ? mdl_b[3] : man_b[3];

  wire [3:0] req_a = {bus_a.update, bus_a.run_backward, bus_a.run_forward, bus_a.zero_grad};
  wire [3:0] req_b = {bus_b.update, bus_b.run_backward, bus_b.run_forward, bus_b.zero_grad};

  wire [3:0]  obs_req   = sel ? req_b : req_a;
  wire [7:0]  obs_fwd   = sel ? bus_b.fwd_idx : bus_a.fwd_idx;
  wire [7:0]  obs_bwd   = sel ? bus_b.bwd_idx : bus_a.bwd_idx;
  wire [15:0] obs_batch = sel ? bus_b.batch_cnt : bus_a.batch_cnt;
  wire        obs_lb    = sel ? bus_b.load_backward : bus_a.load_backward;
  wire        obs_busy  = sel ? bus_b.busy : bus_a.busy;
  wire        obs_done  = sel ? bus_b.done : bus_a.done;

  // Acknowledge model: valid rises dly cycles into a request, lingers hold cycles after it drops.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_a[i]) begin
        hcnt_a[i] = 0;
        if (cnt_a[i] < dly) cnt_a[i] = cnt_a[i] + 1;
        if (cnt_a[i] >= dly) mdl_a[i] = 1'b1;
      end else begin
        cnt_a[i] = 0;
        if (mdl_a[i]) begin
          if (hcnt_a[i] >= hold) begin
            mdl_a[i] = 1'b0;
            hcnt_a[i] = 0;
          end else hcnt_a[i] = hcnt_a[i] + 1;
        end
      end
      if (req_b[i]) begin
        hcnt_b[i] = 0;
        if (cnt_b[i] < dly) cnt_b[i] = cnt_b[i] + 1;
        if (cnt_b[i] >= dly) mdl_b[i] = 1'b1;
      end else begin
        cnt_b[i] = 0;
        if (mdl_b[i]) begin
          if (hcnt_b[i] >= hold) begin
            mdl_b[i] = 1'b0;
            hcnt_b[i] = 0;
          end else hcnt_b[i] = hcnt_b[i] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_req(input logic [3:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_req == want) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Records each request burst (rising from all-quiet) plus pulse counts until done + 5 cycles.
  task automatic run_log(input int budget, output bit ok);
    logic [3:0] prev;
    int tail;
    ev_q.delete();
    lb_cnt = 0;
    done_cnt = 0;
    prev = 4'h0;
    ok = 1'b0;
    tail = 5;
    for (int i = 0; i < budget; i++) begin
      if (obs_req != 4'h0 && prev == 4'h0)
        ev_q.push_back({4'h0, obs_req, obs_fwd, obs_bwd, obs_batch[7:0]});
      prev = obs_req;
      if (obs_lb) lb_cnt++;
      if (obs_done) begin
        done_cnt++;
        ok = 1'b1;
      end
      if (ok) begin
        if (tail == 0) break;
        tail--;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    start_a = 1'b1;
    start_b = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests_run++;
      if ({obs_req, obs_lb, obs_busy, obs_done} !== 7'h00) begin
        tests_failed++;
        $display("FAIL reset_ctrl inst%0d: got %h want 00", s, {obs_req, obs_lb, obs_busy, obs_done});
      end
      tests_run++;
      if ({obs_fwd, obs_bwd, obs_batch} !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_idx inst%0d: got %h want 0", s, {obs_fwd, obs_bwd, obs_batch});
      end
    end
    step();
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests_run++;
      if ({obs_req, obs_busy} !== 5'h00) begin
        tests_failed++;
        $display("FAIL reset_start_ignored inst%0d: got %h want 00", s, {obs_req, obs_busy});
      end
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_b2_sequence();
    bit ok;
    logic [31:0] exp_ev[4];
    logic [31:0] exp_m[4];
    sel = 1'b0;
    auto_a = 4'hF;
    dly = 3;
    hold = 0;
    exp_ev[0] = {4'h0, 4'b0011, 8'd0, 8'd0, 8'd0}; exp_m[0] = M_S1;
    exp_ev[1] = {4'h0, 4'b0110, 8'd1, 8'd0, 8'd0}; exp_m[1] = M_ALL;
    exp_ev[2] = {4'h0, 4'b0100, 8'd0, 8'd1, 8'd0}; exp_m[2] = M_NOFWD;
    exp_ev[3] = {4'h0, 4'b1000, 8'd0, 8'd0, 8'd0}; exp_m[3] = M_REQB;
    pulse_start();
    tests_run++;
    if (obs_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2_busy_after_start: got %b want 1", obs_busy);
    end
    run_log(300, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL b2_done_timeout: got no done want done");
    end
    tests_run++;
    if (ev_q.size() != 4) begin
      tests_failed++;
      $display("FAIL b2_event_count: got %0d want 4", ev_q.size());
    end
    for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
      tests_run++;
      if ((ev_q[i] & exp_m[i]) !== (exp_ev[i] & exp_m[i])) begin
        tests_failed++;
        $display("FAIL b2_event%0d: got %h want %h", i, ev_q[i] & exp_m[i], exp_ev[i] & exp_m[i]);
      end
    end
    tests_run++;
    if (lb_cnt != 2) begin
      tests_failed++;
      $display("FAIL b2_load_backward_pulses: got %0d want 2", lb_cnt);
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL b2_done_pulses: got %0d want 1", done_cnt);
    end
    tests_run++;
    if ({obs_busy, obs_req} !== 5'h00) begin
      tests_failed++;
      $display("FAIL b2_idle_after: got %h want 00", {obs_busy, obs_req});
    end
    $display("[TB] test_b2_sequence complete, %0d events", ev_q.size());
  endtask

  task automatic test_s2_latch();
    bit ok;
    sel = 1'b0;
    auto_a = 4'h0;
    man_a = 4'h0;
    pulse_start();
    man_a = 4'b0011;
    step();
    man_a = 4'h0;
    wait_req(4'b0110, 20, ok);
    tests_run++;
    if (!ok || obs_fwd !== 8'd1 || obs_bwd !== 8'd0) begin
      tests_failed++;
      $display("FAIL s2_entry: got req %b fwd %0d bwd %0d want 0110 1 0", obs_req, obs_fwd, obs_bwd);
    end
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (obs_req !== 4'b0110) begin
        tests_failed++;
        $display("FAIL s2_hold_cycle%0d: got %b want 0110", c, obs_req);
      end
      if (c == 2) man_a[1] = 1'b1;
      if (c == 3) man_a[1] = 1'b0;
      if (c == 9) man_a[2] = 1'b1;
      step();
    end
    tests_run++;
    if (obs_req !== 4'b0000) begin
      tests_failed++;
      $display("FAIL s2_exit: got %b want 0000", obs_req);
    end
    man_a = 4'h0;
    wait_req(4'b0100, 20, ok);
    tests_run++;
    if (!ok || obs_bwd !== 8'd1) begin
      tests_failed++;
      $display("FAIL s2_then_s3: got req %b bwd %0d want 0100 1", obs_req, obs_bwd);
    end
    auto_a = 4'hF;
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL s2_done_timeout: got no done want done");
    end
    step();
    $display("[TB] test_s2_latch complete");
  endtask

  task automatic test_rel_hold();
    bit ok;
    sel = 1'b0;
    auto_a = 4'h0;
    man_a = 4'h0;
    pulse_start();
    man_a = 4'b0011;
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({obs_req, obs_lb} !== 5'h00) begin
        tests_failed++;
        $display("FAIL rel_hold_cycle%0d: got %h want 00", i, {obs_req, obs_lb});
      end
      step();
    end
    man_a = 4'h0;
    step();
    tests_run++;
    if (obs_lb !== 1'b1 || obs_fwd !== 8'd1 || obs_bwd !== 8'd0) begin
      tests_failed++;
      $display("FAIL rel_release: got lb %b fwd %0d bwd %0d want 1 1 0", obs_lb, obs_fwd, obs_bwd);
    end
    auto_a = 4'hF;
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rel_done_timeout: got no done want done");
    end
    step();
    $display("[TB] test_rel_hold complete");
  endtask

  task automatic test_b1_n2();
    bit ok;
    int zg;
    logic [31:0] exp_ev[6];
    logic [31:0] exp_m[6];
    sel = 1'b1;
    auto_b = 4'hF;
    dly = 3;
    hold = 0;
    exp_ev[0] = {4'h0, 4'b0011, 8'd0, 8'd0, 8'd0}; exp_m[0] = M_S1;
    exp_ev[1] = {4'h0, 4'b0100, 8'd0, 8'd0, 8'd0}; exp_m[1] = M_NOFWD;
    exp_ev[2] = {4'h0, 4'b1000, 8'd0, 8'd0, 8'd0}; exp_m[2] = M_REQB;
    exp_ev[3] = {4'h0, 4'b0011, 8'd0, 8'd0, 8'd1}; exp_m[3] = M_S1;
    exp_ev[4] = {4'h0, 4'b0100, 8'd0, 8'd0, 8'd1}; exp_m[4] = M_NOFWD;
    exp_ev[5] = {4'h0, 4'b1000, 8'd0, 8'd0, 8'd1}; exp_m[5] = M_REQB;
    pulse_start();
    run_log(400, ok);
    tests_run++;
    if (!ok || ev_q.size() != 6) begin
      tests_failed++;
      $display("FAIL b1_events: got done %b count %0d want 1 6", ok, ev_q.size());
    end
    for (int i = 0; i < 6 && i < ev_q.size(); i++) begin
      tests_run++;
      if ((ev_q[i] & exp_m[i]) !== (exp_ev[i] & exp_m[i])) begin
        tests_failed++;
        $display("FAIL b1_event%0d: got %h want %h", i, ev_q[i] & exp_m[i], exp_ev[i] & exp_m[i]);
      end
    end
    zg = 0;
    for (int i = 0; i < ev_q.size(); i++) if (ev_q[i][24]) zg++;
    tests_run++;
    if (zg != 2 || done_cnt != 1 || lb_cnt != 2) begin
      tests_failed++;
      $display("FAIL b1_counts: got zg %0d done %0d lb %0d want 2 1 2", zg, done_cnt, lb_cnt);
    end
    $display("[TB] test_b1_n2 complete, %0d events", ev_q.size());
  endtask

  task automatic test_reset_mid();
    bit ok;
    sel = 1'b0;
    auto_a = 4'b0111;
    man_a = 4'h0;
    pulse_start();
    wait_req(4'b1000, 200, ok);
    step();
    tests_run++;
    if (!ok || obs_req !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mid_reach_update: got %b want 1000", obs_req);
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    tests_run++;
    if ({obs_req, obs_lb, obs_busy, obs_done, obs_fwd, obs_bwd, obs_batch} !== 39'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got req %b fwd %0d bwd %0d busy %b want all 0",
               obs_req, obs_fwd, obs_bwd, obs_busy);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({obs_req, obs_busy} !== 5'h00) begin
        tests_failed++;
        $display("FAIL mid_quiet_cycle%0d: got %h want 00", i, {obs_req, obs_busy});
      end
      step();
    end
    auto_a = 4'hF;
    pulse_start();
    tests_run++;
    if (obs_req !== 4'b0011 || obs_fwd !== 8'd0 || obs_batch !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_restart: got req %b fwd %0d batch %0d want 0011 0 0", obs_req, obs_fwd, obs_batch);
    end
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL mid_done_timeout: got no done want done");
    end
    step();
    $display("[TB] test_reset_mid complete");
  endtask

  task automatic test_spurious();
    bit ok;
    sel = 1'b0;
    auto_a = 4'h0;
    man_a = 4'h0;
    pulse_start();
    man_a = 4'b1000;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    tests_run++;
    if (obs_req !== 4'b0011 || obs_fwd !== 8'd0 || obs_busy !== 1'b1 || obs_lb !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_update: got req %b fwd %0d busy %b lb %b want 0011 0 1 0",
               obs_req, obs_fwd, obs_busy, obs_lb);
    end
    man_a = 4'b1001;
    step();
    step();
    tests_run++;
    if (obs_req !== 4'b0011 || obs_fwd !== 8'd0) begin
      tests_failed++;
      $display("FAIL spurious_half_pair: got req %b fwd %0d want 0011 0", obs_req, obs_fwd);
    end
    man_a = 4'h0;
    auto_a = 4'hF;
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL spurious_done_timeout: got no done want done");
    end
    step();
    $display("[TB] test_spurious complete");
  endtask

  task automatic test_back_to_back();
    bit ok;
    sel = 1'b1;
    auto_b = 4'hF;
    pulse_start();
    wait_done(400, ok);
    pulse_start();
    tests_run++;
    if (!ok || obs_req !== 4'b0011 || obs_busy !== 1'b1 || obs_batch !== 16'd0) begin
      tests_failed++;
      $display("FAIL b2b_restart: got done %b req %b busy %b batch %0d want 1 0011 1 0",
               ok, obs_req, obs_busy, obs_batch);
    end
    wait_done(400, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL b2b_done_timeout: got no done want done");
    end
    step();
    $display("[TB] test_back_to_back complete");
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    auto_a = 4'hF;
    auto_b = 4'hF;
    man_a = 4'h0;
    man_b = 4'h0;
    sel = 1'b0;
    dly = 3;
    hold = 0;
    test_reset();
    test_b2_sequence();
    test_s2_latch();
    test_rel_hold();
    test_b1_n2();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
